// File: rtl/bsw_pkg.sv
// Shared sizing, state encoding and payload types for the banded Smith-Waterman sequencer.
package bsw_pkg;

   localparam int unsigned B        = 4;
   localparam int unsigned L        = 8;
   localparam int unsigned SYM_W    = 3;
   localparam int unsigned TB_MAX   = 4 * L;
   localparam int unsigned D        = 2 * L - B;
   localparam int unsigned IDX_W    = $clog2(L);
   localparam int unsigned WAVE_W   = $clog2(2 * L);
   localparam int unsigned ADDR_W   = $clog2(D);
   localparam int unsigned CNT_W    = $clog2(2 * L);
   localparam int unsigned TB_CNT_W = $clog2(TB_MAX);
   localparam int unsigned WR_W     = WAVE_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_Q,
      PRIME_R,
      BAND,
      FLUSH,
      TB,
      DONE
   } state_t;

   // Aligned output pair as written by the traceback datapath.
   typedef struct packed {
      logic [SYM_W-1:0] q;
      logic [SYM_W-1:0] r;
   } sym_pair_t;

endpackage

// File: rtl/bsw_pe_wr_gen.sv
// Per-PE score-memory write strobes and addresses, one cycle after each R shift.
module bsw_pe_wr_gen
   import bsw_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    shift,
   input  logic [WAVE_W-1:0]       wave,
   output logic [B-1:0]            pe_we,
   output logic [B*ADDR_W-1:0]     pe_addr
);

   localparam int unsigned EXT_W = WAVE_W + 1;

   logic [B-1:0]        we_c;
   logic [B*ADDR_W-1:0] addr_c;
   logic [EXT_W-1:0]    w_ext;

   // PE i owns waves i+1 .. i+D; its address is the offset into that window.
   always_comb begin
      we_c   = '0;
      addr_c = '0;
      w_ext  = EXT_W'(wave);
      for (int unsigned i = 0; i < B; i++) begin
         if (shift && (w_ext >= EXT_W'(i + 1)) && (w_ext <= EXT_W'(i + D))) begin
            we_c[i]                     = 1'b1;
            addr_c[i*ADDR_W +: ADDR_W]  = ADDR_W'(w_ext - EXT_W'(i + 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pe_we   <= '0;
         pe_addr <= '0;
      end else begin
         pe_we   <= we_c;
         pe_addr <= addr_c;
      end
   end

endmodule

// File: rtl/bsw_band_sequencer.sv
// Control FSM for the banded Smith-Waterman array: symbol fetch, shift enables,
// score-write generation, traceback supervision and completion/timeout reporting.
module bsw_band_sequencer
   import bsw_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic [IDX_W-1:0]        q_idx,
   output logic [IDX_W-1:0]        r_idx,
   output logic                    r_zero,
   output logic                    en_q,
   output logic                    en_r,
   output logic                    sr_clear,
   output logic [WAVE_W-1:0]       wave,
   output logic [B-1:0]            pe_we,
   output logic [B*ADDR_W-1:0]     pe_addr,
   output logic                    tb_start,
   input  logic                    tb_finish,
   output logic                    out_we,
   output logic [WAVE_W-1:0]       out_idx,
   output logic                    busy,
   output logic                    ready,
   output logic                    tb_err
);

   state_t state, state_nxt;

   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [IDX_W-1:0]    q_ptr, q_ptr_d, r_ptr, r_ptr_d;
   logic [TB_CNT_W-1:0] tb_cnt, tb_cnt_d;
   logic [WR_W-1:0]     wr_cnt, wr_cnt_d;

   logic [IDX_W-1:0]    q_idx_d, r_idx_d;
   logic [WAVE_W-1:0]   wave_d, out_idx_d;
   logic                r_zero_d, en_q_d, en_r_d, sr_clear_d, tb_start_d;
   logic                out_we_d, busy_d, ready_d, tb_err_d;

   logic                go, tb_live, tb_timeout, tb_end;

   // Outputs trail the state by one cycle, so TB cycles count only once tb_start is visible.
   assign go         = start && ((state == IDLE) || (state == DONE));
   assign tb_live    = (state == TB) && tb_start;
   assign tb_timeout = tb_live && !tb_finish && (tb_cnt == TB_CNT_W'(TB_MAX - 1));
   assign tb_end     = tb_live && (tb_finish || tb_timeout);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start)                                  state_nxt = LOAD_Q;
         LOAD_Q:     if (cnt == CNT_W'(B - 1))                   state_nxt = PRIME_R;
         PRIME_R:    if (cnt == CNT_W'(B - 1))                   state_nxt = BAND;
         BAND:       if (cnt == CNT_W'(2 * (L - B) - 1))         state_nxt = FLUSH;
         FLUSH:      if (wave == WAVE_W'(2 * L - 2))             state_nxt = TB;
         TB:         if (tb_end)                                 state_nxt = DONE;
         default:                                                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sr_clear_d = 1'b0;
      en_q_d     = 1'b0;
      en_r_d     = 1'b0;
      r_zero_d   = 1'b0;
      tb_start_d = 1'b0;
      out_we_d   = 1'b0;
      q_idx_d    = q_idx;
      r_idx_d    = r_idx;
      wave_d     = wave;
      out_idx_d  = out_idx;
      tb_err_d   = tb_err;
      q_ptr_d    = q_ptr;
      r_ptr_d    = r_ptr;
      tb_cnt_d   = tb_cnt;
      wr_cnt_d   = wr_cnt;
      busy_d     = (state_nxt != IDLE) && (state_nxt != DONE);
      ready_d    = (state_nxt == DONE);

      if (state_nxt != state)
         cnt_d = '0;
      else if ((state == LOAD_Q) || (state == PRIME_R) || (state == BAND))
         cnt_d = cnt + CNT_W'(1);
      else
         cnt_d = cnt;

      case (state)
         IDLE, DONE: begin
            if (go) begin
               sr_clear_d = 1'b1;
               wave_d     = '0;
               tb_err_d   = 1'b0;
               q_idx_d    = '0;
               r_idx_d    = '0;
               out_idx_d  = '0;
               q_ptr_d    = '0;
               r_ptr_d    = '0;
               tb_cnt_d   = '0;
               wr_cnt_d   = '0;
            end
         end
         LOAD_Q:  en_q_d = 1'b1;
         PRIME_R: en_r_d = 1'b1;
         BAND: begin
            if (!cnt[0]) en_q_d = 1'b1;
            else         en_r_d = 1'b1;
         end
         FLUSH: begin
            en_r_d   = 1'b1;
            r_zero_d = 1'b1;
         end
         TB: begin
            tb_start_d = !tb_end;
            if (tb_live && !tb_finish) begin
               tb_cnt_d = tb_cnt + TB_CNT_W'(1);
               // Writes stop once every output slot 0..2L-1 has been used.
               if (wr_cnt != WR_W'(2 * L)) begin
                  out_we_d  = 1'b1;
                  out_idx_d = WAVE_W'(wr_cnt);
                  wr_cnt_d  = wr_cnt + WR_W'(1);
               end
               if (tb_timeout) tb_err_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (en_q_d) begin
         q_idx_d = q_ptr;
         q_ptr_d = q_ptr + IDX_W'(1);
      end
      if (en_r_d) begin
         wave_d = wave + WAVE_W'(1);
         if (!r_zero_d) begin
            r_idx_d = r_ptr;
            r_ptr_d = r_ptr + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_idx    <= '0;
         r_idx    <= '0;
         r_zero   <= 1'b0;
         en_q     <= 1'b0;
         en_r     <= 1'b0;
         sr_clear <= 1'b0;
         wave     <= '0;
         tb_start <= 1'b0;
         out_we   <= 1'b0;
         out_idx  <= '0;
         busy     <= 1'b0;
         ready    <= 1'b0;
         tb_err   <= 1'b0;
         cnt      <= '0;
         q_ptr    <= '0;
         r_ptr    <= '0;
         tb_cnt   <= '0;
         wr_cnt   <= '0;
      end else begin
         q_idx    <= q_idx_d;
         r_idx    <= r_idx_d;
         r_zero   <= r_zero_d;
         en_q     <= en_q_d;
         en_r     <= en_r_d;
         sr_clear <= sr_clear_d;
         wave     <= wave_d;
         tb_start <= tb_start_d;
         out_we   <= out_we_d;
         out_idx  <= out_idx_d;
         busy     <= busy_d;
         ready    <= ready_d;
         tb_err   <= tb_err_d;
         cnt      <= cnt_d;
         q_ptr    <= q_ptr_d;
         r_ptr    <= r_ptr_d;
         tb_cnt   <= tb_cnt_d;
         wr_cnt   <= wr_cnt_d;
      end
   end

   bsw_pe_wr_gen u_pe_wr_gen (
      .clk     (clk),
      .reset   (reset),
      .shift   (en_r),
      .wave    (wave),
      .pe_we   (pe_we),
      .pe_addr (pe_addr)
   );

endmodule

// File: tb/tb_bsw_band_sequencer.sv
// Randomized self-checking bench for bsw_band_sequencer against a cycle-schedule model.
module tb_bsw_band_sequencer;
   import bsw_pkg::*;

   localparam int C = 3 * L - 1;   // last compute cycle after the sr_clear cycle

   logic                clk = 1'b0;
   logic                reset, start, tb_finish;
   logic [IDX_W-1:0]    q_idx, r_idx;
   logic                r_zero, en_q, en_r, sr_clear;
   logic [WAVE_W-1:0]   wave, out_idx;
   logic [B-1:0]        pe_we;
   logic [B*ADDR_W-1:0] pe_addr;
   logic                tb_start, out_we, busy, ready, tb_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bsw_band_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .q_idx     (q_idx),
      .r_idx     (r_idx),
      .r_zero    (r_zero),
      .en_q      (en_q),
      .en_r      (en_r),
      .sr_clear  (sr_clear),
      .wave      (wave),
      .pe_we     (pe_we),
      .pe_addr   (pe_addr),
      .tb_start  (tb_start),
      .tb_finish (tb_finish),
      .out_we    (out_we),
      .out_idx   (out_idx),
      .busy      (busy),
      .ready     (ready),
      .tb_err    (tb_err)
   );

   // One complete run: k = TB cycles with tb_finish low before it rises (k >= TB_MAX: never rises).
   task automatic test_sequence(input int k, input bit glitch, input bit flush_start);
      bit                  timeout, e_sr, e_q, e_r, e_rz, e_tbs, e_we, e_busy, e_ready, e_err, pshift;
      int                  n_tb, e_cyc, wr_lim, nshift, pwave, j, obs_wr, exp_wr;
      logic [8:0]          exp_ctl, obs_ctl;
      logic [IDX_W-1:0]    eq_idx, er_idx;
      logic [B-1:0]        exp_pe_we;
      logic [B*ADDR_W-1:0] exp_addr, obs_addr;
      timeout = (k >= int'(TB_MAX));
      n_tb    = timeout ? int'(TB_MAX) : k;
      e_cyc   = timeout ? C + 1 + int'(TB_MAX) : C + 2 + k;
      wr_lim  = (n_tb < 2 * int'(L)) ? n_tb : 2 * int'(L);
      nshift = 0; pshift = 0; pwave = 0; obs_wr = 0; exp_wr = 0;
      @(negedge clk);
      start = 1'b1; tb_finish = 1'b0;
      for (int c = 0; c <= e_cyc + 2; c++) begin
         @(negedge clk);
         e_sr = (c == 0); e_q = 0; e_r = 0; e_rz = 0; eq_idx = '0; er_idx = '0;
         if (c >= 1 && c <= int'(B)) begin
            e_q = 1; eq_idx = IDX_W'(c - 1);
         end else if (c > int'(B) && c <= 2 * int'(B)) begin
            e_r = 1; er_idx = IDX_W'(c - int'(B) - 1);
         end else if (c > 2 * int'(B) && c <= 2 * int'(L)) begin
            j = c - 2 * int'(B) - 1;
            if (j % 2 == 0) begin e_q = 1; eq_idx = IDX_W'(int'(B) + j / 2); end
            else            begin e_r = 1; er_idx = IDX_W'(int'(B) + j / 2); end
         end else if (c > 2 * int'(L) && c <= C) begin
            e_r = 1; e_rz = 1;
         end
         if (e_r) nshift++;
         e_tbs   = (c >= C + 1) && (c < e_cyc);
         e_we    = (c >= C + 2) && (c < C + 2 + wr_lim);
         e_busy  = (c < e_cyc);
         e_ready = (c >= e_cyc);
         e_err   = timeout && (c >= e_cyc);
         exp_ctl = {e_sr, e_q, e_r, e_rz, e_tbs, e_we, e_busy, e_ready, e_err};
         obs_ctl = {sr_clear, en_q, en_r, r_zero, tb_start, out_we, busy, ready, tb_err};
         n_tests++;
         if (obs_ctl !== exp_ctl) begin
            n_fail++;
            $display("FAIL ctl k=%0d c=%0d {clr,q,r,rz,tbs,we,busy,rdy,err} got %b exp %b", k, c, obs_ctl, exp_ctl);
         end
         n_tests++;
         if (wave !== WAVE_W'(nshift)) begin
            n_fail++;
            $display("FAIL wave k=%0d c=%0d got %0d exp %0d", k, c, wave, nshift);
         end
         if (e_q) begin
            n_tests++;
            if (q_idx !== eq_idx) begin
               n_fail++;
               $display("FAIL q_idx c=%0d got %0d exp %0d", c, q_idx, eq_idx);
            end
         end
         if (e_r && !e_rz) begin
            n_tests++;
            if (r_idx !== er_idx) begin
               n_fail++;
               $display("FAIL r_idx c=%0d got %0d exp %0d", c, r_idx, er_idx);
            end
         end
         if (e_we) begin
            n_tests++;
            if (out_idx !== WAVE_W'(c - C - 2)) begin
               n_fail++;
               $display("FAIL out_idx c=%0d got %0d exp %0d", c, out_idx, c - C - 2);
            end
         end
         // Score write for the wave produced by the previous cycle's R shift.
         exp_pe_we = '0; exp_addr = '0; obs_addr = '0;
         for (int i = 0; i < int'(B); i++) begin
            if (pshift && (pwave - 1 >= i) && (pwave - 1 < i + int'(D))) begin
               exp_pe_we[i] = 1'b1;
               exp_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(pwave - 1 - i);
               obs_addr[i*ADDR_W +: ADDR_W] = pe_addr[i*ADDR_W +: ADDR_W];
            end
         end
         n_tests++;
         if ({pe_we, obs_addr} !== {exp_pe_we, exp_addr}) begin
            n_fail++;
            $display("FAIL pe_wr c=%0d we/addr got %b/%h exp %b/%h", c, pe_we, obs_addr, exp_pe_we, exp_addr);
         end
         obs_wr += $countones(pe_we);
         exp_wr += $countones(exp_pe_we);
         pshift = e_r; pwave = nshift;
         start = 1'b0;
         if (glitch && c >= 1 && c < C && $urandom_range(0, 3) == 0) start = 1'b1;
         if (flush_start && c == 2 * int'(L) + 3) start = 1'b1;
         tb_finish = 1'b0;
         if (c < C || c >= e_cyc)            tb_finish = 1'($urandom_range(0, 1));
         else if (!timeout && c == C + 1 + k) tb_finish = 1'b1;
      end
      n_tests++;
      if (obs_wr != exp_wr) begin
         n_fail++;
         $display("FAIL pe_write_total k=%0d got %0d exp %0d", k, obs_wr, exp_wr);
      end
      start = 1'b0; tb_finish = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; tb_finish = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({q_idx, r_idx, r_zero, en_q, en_r, sr_clear, wave, pe_we, pe_addr,
           tb_start, out_we, out_idx, busy, ready, tb_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b ready=%b en_q=%b en_r=%b wave=%0d exp all 0", busy, ready, en_q, en_r, wave);
      end
      reset = 1'b1;
   endtask

   task automatic test_full_run;
      test_sequence(10, 1'b0, 1'b0);
   endtask

   task automatic test_timeout;
      test_sequence(int'(TB_MAX) + 4, 1'b0, 1'b0);
      n_tests++;
      if ({tb_err, ready, out_idx} !== {1'b1, 1'b1, WAVE_W'(2 * L - 1)}) begin
         n_fail++;
         $display("FAIL timeout_final got err=%b rdy=%b out_idx=%0d exp 1 1 %0d", tb_err, ready, out_idx, 2 * L - 1);
      end
   endtask

   task automatic test_start_ignored;
      test_sequence(int'($urandom_range(0, 20)), 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back;
      test_sequence(0, 1'b1, 1'b0);
      test_sequence(int'(TB_MAX) - 1, 1'b0, 1'b0);
      test_sequence(int'(2 * L), 1'b1, 1'b0);
      for (int n = 0; n < 4; n++)
         test_sequence(int'($urandom_range(0, TB_MAX + 3)), 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic test_reset_mid_band;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_band_busy got %b exp 1", busy);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({q_idx, r_idx, r_zero, en_q, en_r, sr_clear, wave, pe_we, pe_addr,
           tb_start, out_we, out_idx, busy, ready, tb_err} !== '0) begin
         n_fail++;
         $display("FAIL mid_band_reset got busy=%b en_q=%b en_r=%b wave=%0d pe_we=%b exp all 0", busy, en_q, en_r, wave, pe_we);
      end
      test_sequence(5, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; tb_finish = 1'b0;
      test_reset;
      test_full_run;
      test_timeout;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_band;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
